fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_pc.sv | 43 ++++
 rtl/fetch_sequencer.sv | 146 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer: default widths,
// the all-zero halt word and the sequencer state type.
package fetch_pkg;

  localparam int unsigned FETCH_ADDR_W  = 4;
  localparam int unsigned FETCH_INSTR_W = 16;

  // Unprogrammed-memory fill pattern; treated as a halt when the zero-halt feature is built in.
  localparam logic [FETCH_INSTR_W-1:0] HALT_WORD = '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

endpackage

// File: rtl/fetch_pc.sv
// Program counter register: clear to 0, load a redirect target, or
// increment with natural wrap at 2^ADDR_W. Priority: clear > load > inc.
module fetch_pc
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = FETCH_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] target_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  // Next PC selection; the adder drops its carry so 2^ADDR_W-1 wraps to 0.
  always_comb begin
    pc_d = pc_q;
    if (clr_i) begin
      pc_d = '0;
    end else if (load_i) begin
      pc_d = target_i;
    end else if (inc_i) begin
      pc_d = pc_q + ADDR_W'(1);
    end
  end

  // PC register with asynchronous reset to address 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: walks the PC through a combinational
// instruction memory into a single-entry instruction register with
// valid/ready handshake and branch redirect.
// Optional feature macro FETCH_ZERO_HALT_EN: an all-zero word stops
// fetching and parks the sequencer in HALT until the next start.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W  = FETCH_ADDR_W,
  parameter int unsigned INSTR_W = FETCH_INSTR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic               ir_valid,
  input  logic               ir_ready,
  output logic [INSTR_W-1:0] ir_instr,
  output logic [ADDR_W-1:0]  ir_pc,
  input  logic               br_valid,
  input  logic [ADDR_W-1:0]  br_target,
  output logic               busy,
  output logic               halted
);

  state_e             state_q;
  state_e             state_d;
  logic               ir_valid_q;
  logic               ir_valid_d;
  logic [INSTR_W-1:0] ir_instr_q;
  logic [ADDR_W-1:0]  ir_pc_q;
  logic               busy_q;
  logic [ADDR_W-1:0]  pc;

  logic               attempt_c;
  logic               load_c;
  logic               halt_go_c;
  logic               pc_clr_c;
  logic               pc_br_c;

  // Fetch decisions: a fetch is attempted when running, the IR slot frees
  // this cycle and no redirect is pending.
  always_comb begin
    attempt_c = (state_q == ST_RUN) && (!ir_valid_q || ir_ready) && !br_valid;
`ifdef FETCH_ZERO_HALT_EN
    halt_go_c = attempt_c && (imem_instr == INSTR_W'(HALT_WORD));
`else
    halt_go_c = 1'b0;
`endif
    load_c    = attempt_c && !halt_go_c;
    pc_clr_c  = start && (state_q != ST_RUN);
    pc_br_c   = (state_q == ST_RUN) && br_valid;
  end

  // Next state and next IR-valid; a branch wins over a pending accept.
  always_comb begin
    state_d    = state_q;
    ir_valid_d = ir_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_RUN;
          ir_valid_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (br_valid) begin
          ir_valid_d = 1'b0;
        end else if (load_c) begin
          ir_valid_d = 1'b1;
        end else if (halt_go_c) begin
          state_d    = ST_HALT;
          ir_valid_d = ir_valid_q && !ir_ready;
        end
      end
      ST_HALT: begin
        if (start) begin
          state_d    = ST_RUN;
          ir_valid_d = 1'b0;
        end else if (ir_ready) begin
          ir_valid_d = 1'b0;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        ir_valid_d = 1'b0;
      end
    endcase
  end

  // State, status flags and instruction register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      ir_valid_q <= 1'b0;
      ir_instr_q <= '0;
      ir_pc_q    <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= (state_d == ST_RUN);
      ir_valid_q <= ir_valid_d;
      if (load_c) begin
        ir_instr_q <= imem_instr;
        ir_pc_q    <= pc;
      end
    end
  end

`ifdef FETCH_ZERO_HALT_EN
  logic halted_q;

  // Halt flag tracks entry into and exit from HALT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= (state_d == ST_HALT);
    end
  end

  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

  fetch_pc #(
    .ADDR_W (ADDR_W)
  ) u_pc (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (pc_clr_c),
    .load_i   (pc_br_c),
    .target_i (br_target),
    .inc_i    (load_c),
    .pc_o     (pc)
  );

  assign imem_addr = pc;
  assign ir_valid  = ir_valid_q;
  assign ir_instr  = ir_instr_q;
  assign ir_pc     = ir_pc_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios followed by random traffic,
// all checked against a cycle-level behavioural model of the fetch rules.
module tb_fetch_sequencer;

  localparam int unsigned AW = 4;
  localparam int unsigned IW = 16;

  logic          clk;
  logic          rst;
  logic          start;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_instr;
  logic          ir_valid;
  logic          ir_ready;
  logic [IW-1:0] ir_instr;
  logic [AW-1:0] ir_pc;
  logic          br_valid;
  logic [AW-1:0] br_target;
  logic          busy;
  logic          halted;

  logic [IW-1:0] mem [16];

  int total = 0;
  int bad   = 0;

`ifdef FETCH_ZERO_HALT_EN
  localparam bit ZH = 1'b1;
`else
  localparam bit ZH = 1'b0;
`endif

  // Model state: 0 idle, 1 run, 2 halt; PC held as a plain integer.
  int          m_st;
  int          m_pc;
  bit          m_valid;
  int unsigned m_instr;
  int          m_irpc;

  fetch_sequencer #(.ADDR_W(AW), .INSTR_W(IW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .imem_addr  (imem_addr),
    .imem_instr (imem_instr),
    .ir_valid   (ir_valid),
    .ir_ready   (ir_ready),
    .ir_instr   (ir_instr),
    .ir_pc      (ir_pc),
    .br_valid   (br_valid),
    .br_target  (br_target),
    .busy       (busy),
    .halted     (halted)
  );

  assign imem_instr = mem[imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_pc = 0; m_valid = 1'b0; m_instr = 0; m_irpc = 0;
  endtask

  // One clock of the fetch rules, evaluated on the inputs present before the edge.
  task automatic model_step(input bit s, input bit rdy, input bit brv, input int brt);
    int unsigned w;
    if (m_st == 0) begin
      if (s) begin m_st = 1; m_pc = 0; m_valid = 1'b0; end
    end else if (m_st == 1) begin
      if (brv) begin
        m_pc = brt; m_valid = 1'b0;
      end else if (!m_valid || rdy) begin
        w = int'(mem[m_pc]);
        if (ZH && w == 0) begin
          m_st = 2;
          if (rdy) m_valid = 1'b0;
        end else begin
          m_instr = w; m_irpc = m_pc; m_valid = 1'b1;
          m_pc = (m_pc + 1) % 16;
        end
      end
    end else begin
      if (s) begin m_st = 1; m_pc = 0; m_valid = 1'b0; end
      else if (rdy) m_valid = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".imem_addr"}, 32'(imem_addr), 32'(m_pc));
    chk({tag, ".ir_valid"},  32'(ir_valid),  32'(m_valid));
    chk({tag, ".ir_instr"},  32'(ir_instr),  m_instr);
    chk({tag, ".ir_pc"},     32'(ir_pc),     32'(m_irpc));
    chk({tag, ".busy"},      32'(busy),      32'(m_st == 1));
    chk({tag, ".halted"},    32'(halted),    32'(m_st == 2));
  endtask

  // Apply inputs for one cycle, advance model and DUT, then compare.
  task automatic cyc(input string tag, input bit s, input bit rdy, input bit brv, input int brt);
    start = s; ir_ready = rdy; br_valid = brv; br_target = AW'(brt);
    model_step(s, rdy, brv, brt);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = IW'(16'h1000 + i * 16'h0111);
    rst = 1'b1; start = 1'b0; ir_ready = 1'b0; br_valid = 1'b0; br_target = '0;
    model_reset();
    @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;

    // Straight-line run from address 0.
    cyc("start", 1, 1, 0, 0);
    chk("start_valid_low", 32'(ir_valid), 32'd0);
    chk("start_busy", 32'(busy), 32'd1);
    cyc("run0", 0, 1, 0, 0);
    chk("run0_pc", 32'(ir_pc), 32'd0);
    chk("run0_instr", 32'(ir_instr), 32'h1000);
    cyc("run1", 0, 1, 0, 0);
    chk("run1_pc", 32'(ir_pc), 32'd1);
    cyc("run2", 0, 1, 0, 0);
    chk("run2_pc", 32'(ir_pc), 32'd2);

    // Backpressure while word 2 is held.
    for (int i = 0; i < 3; i++) begin
      cyc("stall", 0, 0, 0, 0);
      chk("stall_pc", 32'(ir_pc), 32'd2);
      chk("stall_addr", 32'(imem_addr), 32'd3);
    end
    cyc("release", 0, 1, 0, 0);
    chk("release_pc", 32'(ir_pc), 32'd3);

    // Branch with simultaneous accept; start ignored while running.
    cyc("branch", 1, 1, 1, 6);
    chk("branch_valid", 32'(ir_valid), 32'd0);
    chk("branch_addr", 32'(imem_addr), 32'd6);
    cyc("post_branch", 0, 1, 0, 0);
    chk("post_branch_pc", 32'(ir_pc), 32'd6);

    // Wrap from 15 to 0 without leaving RUN.
    cyc("br14", 0, 1, 1, 14);
    for (int i = 0; i < 4; i++) begin
      cyc("wrap", 0, 1, 0, 0);
      chk("wrap_pc", 32'(ir_pc), 32'((14 + i) % 16));
      chk("wrap_busy", 32'(busy), 32'd1);
    end

    // Zero word at address 8.
    mem[8] = '0;
    cyc("br5", 0, 1, 1, 5);
    cyc("z5", 0, 1, 0, 0);
    cyc("z6", 0, 1, 0, 0);
    cyc("z7", 0, 1, 0, 0);
    chk("z7_pc", 32'(ir_pc), 32'd7);
    cyc("z8", 0, 1, 0, 0);
`ifdef FETCH_ZERO_HALT_EN
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_addr", 32'(imem_addr), 32'd8);
    chk("halt_valid", 32'(ir_valid), 32'd0);
    cyc("halt_br_ignored", 0, 1, 1, 3);
    chk("halt_br_addr", 32'(imem_addr), 32'd8);
    cyc("restart", 1, 1, 0, 0);
    cyc("restart0", 0, 1, 0, 0);
    chk("restart_pc", 32'(ir_pc), 32'd0);
`else
    chk("zero_load_pc", 32'(ir_pc), 32'd8);
    chk("zero_load_instr", 32'(ir_instr), 32'd0);
    chk("zero_halted", 32'(halted), 32'd0);
`endif
    mem[8] = IW'(16'h1888);

    // Asynchronous reset between edges discards everything.
    cyc("pre_rst", 0, 1, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    #1;
    rst = 1'b0;
    cyc("idle_br_ignored", 0, 1, 1, 9);
    cyc("idle_hold", 0, 1, 0, 0);
    chk("idle_valid", 32'(ir_valid), 32'd0);

    // Random traffic against the model; some words zero to reach HALT.
    for (int i = 0; i < 16; i++)
      mem[i] = ($urandom_range(0, 5) == 0) ? '0 : IW'($urandom_range(1, 16'hffff));
    cyc("rnd_start", 1, 1, 0, 0);
    for (int n = 0; n < 400; n++) begin
      cyc("rnd", ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 7),
          ($urandom_range(0, 7) == 0), int'($urandom_range(0, 15)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
